f15_line_acc: RTL and testbench

//  Multi-channel line accumulator for the fosphor histogram/waterfall path.

---
 rtl/f15_line_acc_pkg.sv | 23 ++
 rtl/f15_line_acc_if.sv | 27 ++
 rtl/f15_lacc_ram.sv | 27 ++
 rtl/f15_line_acc.sv | 164 ++++++++++++++++
 tb/tb_f15_line_acc.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/f15_line_acc_pkg.sv
// rtl/f15_line_acc_pkg.sv - shared combine-mode encoding and width helper for the line accumulator
package f15_line_acc_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_MAX   = 2'd1,
        MODE_AVG   = 2'd2,
        MODE_DECAY = 2'd3
    } mode_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/f15_line_acc_if.sv
// rtl/f15_line_acc_if.sv - bin stream in, combined bin stream out, plus per-line controls
interface f15_line_acc_if #(
    parameter int DWIDTH = 18,
    parameter int CW     = 2,
    parameter int AWW    = 4
);
    logic [DWIDTH-1:0] in_data;
    logic [CW-1:0]     in_chan;
    logic              in_valid;
    logic [1:0]        mode;
    logic [AWW-1:0]    alpha;
    logic [DWIDTH-1:0] decay;
    logic              clear;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_last;

    modport master (
        output in_data, in_chan, in_valid, mode, alpha, decay, clear,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_chan, in_valid, mode, alpha, decay, clear,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/f15_lacc_ram.sv
// rtl/f15_lacc_ram.sv - simple dual-port line store, registered read plus output register
module f15_lacc_ram #(
    parameter int AW     = 12,
    parameter int DEPTH  = 4096,
    parameter int DWIDTH = 18
) (
    input  logic              clk,
    input  logic              wr_ena,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_ena,
    input  logic [AW-1:0]     rd_addr,
    output logic [DWIDTH-1:0] rd_data
);
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_ena) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_ena) begin
            rd_q <= mem[rd_addr];
        end
        rd_data <= rd_q;
    end
endmodule

// File: rtl/f15_line_acc.sv
// rtl/f15_line_acc.sv - multi-channel spectrum line accumulator (read-modify-write per bin)
// Each accepted bin reads its stored value, combines it with the new bin, and writes back 3 cycles later.
module f15_line_acc
    import f15_line_acc_pkg::*;
#(
    parameter int LOG2LEN = 10,
    parameter int NCH     = 4,
    parameter int DWIDTH  = 18,
    parameter int AWW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    f15_line_acc_if.slave bus
);
    localparam int CW    = (NCH > 1) ? clog2(NCH) : 1;
    localparam int AW    = CW + LOG2LEN;
    localparam int DEPTH = NCH << LOG2LEN;

    // Shorter lines would let a write-back overlap the next read of the same address.
    generate
        if (LOG2LEN < 2) begin : g_len_check
            $error("f15_line_acc: LOG2LEN must be at least 2");
        end
    endgenerate

    logic [LOG2LEN-1:0] bin;
    logic               bin_first;
    logic               bin_last;
    logic               accept_first;
    logic [NCH-1:0]     clr_pend;
    logic [NCH-1:0]     clr_pend_next;
    logic               clr_hit;

    mode_t              cfg_mode;
    logic [AWW-1:0]     cfg_alpha;
    logic [DWIDTH-1:0]  cfg_decay;
    mode_t              line_mode;
    logic [AWW-1:0]     line_alpha;
    logic [DWIDTH-1:0]  line_decay;

    logic [AW-1:0]      rd_addr;
    logic               s1_valid, s2_valid;
    logic [AW-1:0]      s1_addr, s2_addr, wr_addr;
    logic [DWIDTH-1:0]  s1_x, s2_x;
    mode_t              s1_mode, s2_mode;
    logic [AWW-1:0]     s1_alpha, s2_alpha;
    logic [DWIDTH-1:0]  s1_decay, s2_decay;
    logic               s1_last, s2_last;

    logic [DWIDTH-1:0]  old_data;
    logic [DWIDTH-1:0]  comb_res;
    logic [DWIDTH-1:0]  floor_o;
    logic signed [DWIDTH:0] diff;
    logic signed [DWIDTH:0] step;
    logic               ram_wr_ena;

    // Bin 0 takes its settings straight from the inputs; later bins use the latched copy.
    always_comb begin
        bin_first    = (bin == '0);
        bin_last     = (bin == '1);
        accept_first = bus.in_valid && bin_first;
        clr_hit      = clr_pend[bus.in_chan] || bus.clear;
        line_mode    = cfg_mode;
        line_alpha   = cfg_alpha;
        line_decay   = cfg_decay;
        if (bin_first) begin
            line_mode  = clr_hit ? MODE_PASS : mode_t'(bus.mode);
            line_alpha = bus.alpha;
            line_decay = bus.decay;
        end
        clr_pend_next = clr_pend | {NCH{bus.clear}};
        if (accept_first) begin
            clr_pend_next[bus.in_chan] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin      <= '0;
            clr_pend <= '1;
        end else begin
            if (bus.in_valid) begin
                bin <= bin + LOG2LEN'(1);
            end
            clr_pend <= clr_pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_first) begin
            cfg_mode  <= line_mode;
            cfg_alpha <= line_alpha;
            cfg_decay <= line_decay;
        end
    end

    assign rd_addr = {bus.in_chan, bin};

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            s1_valid      <= bus.in_valid;
            s2_valid      <= s1_valid;
            bus.out_valid <= s2_valid;
            bus.out_last  <= s2_valid && s2_last;
            if (s2_valid) begin
                bus.out_data <= comb_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        s1_addr  <= rd_addr;
        s1_x     <= bus.in_data;
        s1_mode  <= line_mode;
        s1_alpha <= line_alpha;
        s1_decay <= line_decay;
        s1_last  <= bin_last;
        s2_addr  <= s1_addr;
        s2_x     <= s1_x;
        s2_mode  <= s1_mode;
        s2_alpha <= s1_alpha;
        s2_decay <= s1_decay;
        s2_last  <= s1_last;
        wr_addr  <= s2_addr;
    end

    // The average step is bounded by |x-o|, so the modular sum never leaves [min, max].
    always_comb begin
        diff     = $signed({1'b0, s2_x}) - $signed({1'b0, old_data});
        step     = diff >>> s2_alpha;
        floor_o  = (old_data > s2_decay) ? (old_data - s2_decay) : '0;
        comb_res = s2_x;
        case (s2_mode)
            MODE_PASS:  comb_res = s2_x;
            MODE_MAX:   comb_res = (s2_x > old_data) ? s2_x : old_data;
            MODE_AVG:   comb_res = DWIDTH'({1'b0, old_data} + $unsigned(step));
            MODE_DECAY: comb_res = (s2_x > floor_o) ? s2_x : floor_o;
            default:    comb_res = s2_x;
        endcase
    end

    // A reset cycle drops the write-back that is on the bus at that moment.
    assign ram_wr_ena = bus.out_valid && !rst;

    f15_lacc_ram #(
        .AW     (AW),
        .DEPTH  (DEPTH),
        .DWIDTH (DWIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_ena  (ram_wr_ena),
        .wr_addr (wr_addr),
        .wr_data (bus.out_data),
        .rd_ena  (bus.in_valid),
        .rd_addr (rd_addr),
        .rd_data (old_data)
    );
endmodule

// File: tb/tb_f15_line_acc.sv
// tb/tb_f15_line_acc.sv - directed bench for f15_line_acc (LOG2LEN=3, NCH=2, DWIDTH=18)
module tb_f15_line_acc;
    import f15_line_acc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    f15_line_acc_if #(.DWIDTH(18), .CW(1), .AWW(4)) bus ();

    f15_line_acc #(
        .LOG2LEN (3),
        .NCH     (2),
        .DWIDTH  (18),
        .AWW     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int data;
        int last;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bin_t = 0;
    bit   clr_model[2];
    bit   clr_next = 1'b0;
    bit   line_pass = 1'b0;
    int   cur_mode, cur_alpha, cur_decay;
    int   mem_model[2][8];
    int   vx[8];
    int   ve[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_comb(input int m, input int a, input int d, input int o, input int x);
        int s;
        case (m)
            1: return (x > o) ? x : o;
            2: return o + ((x - o) >>> a);
            3: begin
                s = (o > d) ? o - d : 0;
                return (x > s) ? x : s;
            end
            default: return x;
        endcase
    endfunction

    always @(negedge clk) begin
        bit   due;
        exp_t e;
        due = (q.size() > 0) && (q[0].due == cyc);
        if (bus.out_valid === 1'b1 || due) begin
            check("out_valid", bus.out_valid, due);
            if (due) begin
                e = q.pop_front();
                if (bus.out_valid === 1'b1) begin
                    check("out_data", bus.out_data, e.data);
                    check("out_last", bus.out_last, e.last);
                end
            end
        end
    end

    task automatic send(input int ch, input int x, input int exp_hand, input bit use_model);
        int e;
        @(posedge clk);
        #1;
        if (bin_t == 0) begin
            line_pass = clr_model[ch] | clr_next;
            cur_mode  = bus.mode;
            cur_alpha = bus.alpha;
            cur_decay = bus.decay;
        end
        if (clr_next) begin
            clr_model[0] = 1'b1;
            clr_model[1] = 1'b1;
        end
        if (bin_t == 0) clr_model[ch] = 1'b0;
        if (use_model)
            e = line_pass ? x : ref_comb(cur_mode, cur_alpha, cur_decay, mem_model[ch][bin_t], x);
        else
            e = exp_hand;
        bus.clear    = clr_next;
        clr_next     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = x[17:0];
        bus.in_chan  = ch[0];
        q.push_back('{e, int'(bin_t == 7), cyc + 3});
        mem_model[ch][bin_t] = e;
        bin_t = (bin_t + 1) % 8;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            bus.clear    = 1'b0;
        end
    endtask

    task automatic hand_line(input int ch);
        for (int i = 0; i < 8; i++) send(ch, vx[i], ve[i], 1'b0);
    endtask

    task automatic model_line(input int ch, input int max_gap);
        int g;
        for (int i = 0; i < 8; i++) begin
            send(ch, int'($urandom_range(0, 262143)), 0, 1'b1);
            g = int'($urandom_range(0, max_gap));
            if (g > 0) idle(g);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_chan  = '0;
        bus.mode     = 2'd0;
        bus.alpha    = '0;
        bus.decay    = '0;
        bus.clear    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_data", bus.out_data, 0);
        rst = 1'b0;
        clr_model[0] = 1'b1;
        clr_model[1] = 1'b1;

        // max mode, but the first line after reset is cleared
        bus.mode = 2'd1;
        vx = '{5, 3, 9, 0, 7, 1, 2, 4};
        ve = '{5, 3, 9, 0, 7, 1, 2, 4};
        hand_line(0);
        vx = '{4, 4, 4, 4, 4, 4, 4, 4};
        ve = '{5, 4, 9, 4, 7, 4, 4, 4};
        hand_line(0);
        idle(2);

        // average, alpha=1, on channel 1
        bus.mode  = 2'd2;
        bus.alpha = 4'd1;
        vx = '{100, 0, 50, 50, 50, 50, 50, 50};
        ve = '{100, 0, 50, 50, 50, 50, 50, 50};
        hand_line(1);
        vx = '{0, 262143, 0, 50, 50, 50, 50, 50};
        ve = '{50, 131071, 25, 50, 50, 50, 50, 50};
        hand_line(1);
        vx = '{0, 0, 0, 0, 0, 0, 0, 0};
        ve = '{25, 65535, 12, 25, 25, 25, 25, 25};
        hand_line(1);
        idle(1);

        // decay-max with decay=10 on channel 0
        bus.mode = 2'd0;
        vx = '{50, 50, 50, 50, 7, 50, 50, 50};
        ve = '{50, 50, 50, 50, 7, 50, 50, 50};
        hand_line(0);
        bus.mode  = 2'd3;
        bus.decay = 18'd10;
        vx = '{0, 0, 0, 0, 2, 0, 12, 45};
        ve = '{40, 40, 40, 40, 2, 40, 40, 45};
        hand_line(0);

        // mode change at bin 4 is ignored; clear at bin 5 hits the next line
        bus.mode = 2'd1;
        send(0, 41, 41, 1'b0);
        send(0, 0, 40, 1'b0);
        send(0, 0, 40, 1'b0);
        send(0, 0, 40, 1'b0);
        bus.mode = 2'd0;
        send(0, 0, 2, 1'b0);
        clr_next = 1'b1;
        send(0, 0, 40, 1'b0);
        send(0, 0, 40, 1'b0);
        send(0, 0, 45, 1'b0);
        bus.mode = 2'd1;
        vx = '{1, 2, 3, 4, 5, 6, 7, 8};
        ve = '{1, 2, 3, 4, 5, 6, 7, 8};
        hand_line(0);
        idle(3);

        // interleaved channels with random modes and input gaps
        for (int l = 0; l < 6; l++) begin
            bus.mode  = 2'($urandom_range(1, 3));
            bus.alpha = 4'($urandom_range(0, 3));
            bus.decay = 18'($urandom_range(0, 5000));
            model_line(l % 2, 2);
        end
        idle(4);

        // reset mid-line with write-backs in flight
        bus.mode = 2'd1;
        for (int i = 0; i < 5; i++) send(1, 1000 + i, 0, 1'b1);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_midline_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        q.delete();
        bin_t = 0;
        clr_model[0] = 1'b1;
        clr_model[1] = 1'b1;
        vx = '{7, 70, 700, 7000, 3, 30, 300, 3000};
        ve = '{7, 70, 700, 7000, 3, 30, 300, 3000};
        hand_line(1);
        vx = '{0, 100, 0, 0, 0, 0, 0, 5000};
        ve = '{7, 100, 700, 7000, 3, 30, 300, 5000};
        hand_line(1);
        idle(8);
        check("drain_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
